cla_pipe_acc: RTL and testbench

// Parametrised, pipelined carry-lookahead adder/accumulator for the subarray MAC datapath.
// - Splits WIDTH into 16-bit CLA slices, one slice per pipeline stage; the carry is registered between stages.
// - Adds a valid/ready handshake with backpressure.
// - Modes: add, subtract, saturating signed add, and an internal accumulator for partial-sum reduction.

---
 rtl/cla_pipe_acc.sv | 191 +++++++++++++++++++
 tb/tb_cla_pipe_acc.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_acc.sv
// Pipelined carry-lookahead adder/accumulator: one 16-bit CLA slice per stage with the
// carry registered between stages, valid/ready backpressure and an internal accumulator.
module cla_pipe_acc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 16;
    localparam int LAST   = NSLICE - 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_SAT = 2'b11;

    // Flattened lookahead: each carry is a sum of generate terms gated by the propagate chain.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        logic [15:0] g;
        logic [15:0] p;
        logic [16:0] c;
        logic        term;
        logic        prod;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 16; i++) begin
            term = 1'b0;
            prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & ci);
        end
        return {c[16], p ^ c[15:0]};
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_fn(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic             en;
    logic             accept;
    logic [WIDTH-1:0] acc;
    logic             acc_busy;

    logic [WIDTH-1:0] a_p    [NSLICE];
    logic [WIDTH-1:0] b_p    [NSLICE];
    logic [WIDTH-1:0] r_p    [NSLICE];
    logic [1:0]       mode_p [NSLICE];
    logic             clr_p  [NSLICE];
    logic             vld_p  [NSLICE];
    logic             c_p    [NSLICE];

    logic [WIDTH-1:0] st_a    [NSLICE];
    logic [WIDTH-1:0] st_b    [NSLICE];
    logic [WIDTH-1:0] st_r    [NSLICE];
    logic [WIDTH-1:0] nx_r    [NSLICE];
    logic [1:0]       st_mode [NSLICE];
    logic             st_clr  [NSLICE];
    logic             st_vld  [NSLICE];
    logic             st_c    [NSLICE];
    logic             nx_c    [NSLICE];

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sum_nx;
    logic             ovf_nx;

    assign out_valid = vld_p[LAST];
    assign cout      = c_p[LAST];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en && !acc_busy;
    assign accept    = in_valid && in_ready;

    always_comb begin
        b_eff   = b;
        cin_eff = 1'b0;
        case (mode)
            MODE_ADD: cin_eff = cin;
            MODE_SUB: begin
                b_eff   = ~b;
                cin_eff = 1'b1;
            end
            MODE_ACC: b_eff = acc_clr ? '0 : acc;
            default:  cin_eff = 1'b0;
        endcase
    end

    // Stage k adds slice k; upper operand slices ride along, lower result slices are carried forward.
    always_comb begin
        logic [16:0] t;
        t = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (k == 0) begin
                st_a[k]    = a;
                st_b[k]    = b_eff;
                st_r[k]    = '0;
                st_c[k]    = cin_eff;
                st_vld[k]  = accept;
                st_mode[k] = mode;
                st_clr[k]  = acc_clr;
            end else begin
                st_a[k]    = a_p[k-1];
                st_b[k]    = b_p[k-1];
                st_r[k]    = r_p[k-1];
                st_c[k]    = c_p[k-1];
                st_vld[k]  = vld_p[k-1];
                st_mode[k] = mode_p[k-1];
                st_clr[k]  = clr_p[k-1];
            end
            t                   = cla16(st_a[k][16*k +: 16], st_b[k][16*k +: 16], st_c[k]);
            nx_c[k]             = t[16];
            nx_r[k]             = st_r[k];
            nx_r[k][16*k +: 16] = t[15:0];
        end
    end

    always_comb begin
        raw    = nx_r[LAST];
        ovf_nx = (st_a[LAST][MSB] == st_b[LAST][MSB]) && (raw[MSB] != st_a[LAST][MSB]);
        sum_nx = raw;
        if (st_mode[LAST] == MODE_SAT && ovf_nx)
            sum_nx = sat_fn(st_a[LAST][MSB]);
    end

    // Stage boundary: datapath registers, no reset needed
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < NSLICE; k++) begin
                a_p[k]    <= st_a[k];
                b_p[k]    <= st_b[k];
                r_p[k]    <= nx_r[k];
                mode_p[k] <= st_mode[k];
                clr_p[k]  <= st_clr[k];
            end
        end
    end

    // Stage boundary: valids, carries, result and accumulator state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSLICE; k++) begin
                vld_p[k] <= 1'b0;
                c_p[k]   <= 1'b0;
            end
            sum      <= '0;
            ovf      <= 1'b0;
            acc      <= '0;
            acc_busy <= 1'b0;
        end else begin
            if (en) begin
                for (int k = 0; k < NSLICE; k++) begin
                    vld_p[k] <= st_vld[k];
                    c_p[k]   <= nx_c[k];
                end
                if (st_vld[LAST]) begin
                    sum <= sum_nx;
                    ovf <= ovf_nx;
                    if (st_mode[LAST] == MODE_ACC)
                        acc <= sum_nx;
                    else if (st_clr[LAST])
                        acc <= '0;
                end
            end
            if (en && st_vld[LAST] && st_mode[LAST] == MODE_ACC)
                acc_busy <= 1'b0;
            else if (accept && mode == MODE_ACC)
                acc_busy <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cla_pipe_acc.sv
// Randomised and directed bench for cla_pipe_acc against a plain-arithmetic reference model.
module tb_cla_pipe_acc;

    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        mode = 2'b00;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              cin = 1'b0;
    logic              acc_clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              ovf;

    cla_pipe_acc #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .cin(cin), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        is_acc;
        int          acc_cyc;
        logic        lat_chk;
        logic        seen;
        logic        lit_chk;
        logic [31:0] lit_sum;
        logic        lit_cout;
        logic        lit_ovf;
    } item_t;

    item_t q[$];

    // Driver-owned side information read by the monitor
    logic        lit_chk = 1'b0;
    logic [31:0] lit_sum = '0;
    logic        lit_cout = 1'b0;
    logic        lit_ovf = 1'b0;
    logic        lat_chk = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        done = 1'b0;

    // Reference: returns {ovf, cout, sum}
    function automatic logic [33:0] model(input logic [1:0] m, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci,
                                          input logic clr, input logic [31:0] accv);
        logic [31:0] bb;
        logic [32:0] full;
        logic [31:0] res;
        logic        co;
        logic        o;
        if (m == 2'b01) begin
            bb  = ~y;
            res = x - y;
            co  = (x >= y);
        end else begin
            bb   = (m == 2'b10) ? (clr ? 32'd0 : accv) : y;
            full = {1'b0, x} + {1'b0, bb} + {32'd0, (m == 2'b00) ? ci : 1'b0};
            res  = full[31:0];
            co   = full[32];
        end
        o = (x[31] == bb[31]) && (res[31] != x[31]);
        if (m == 2'b11 && o) res = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {o, co, res};
    endfunction

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_acc = '0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out = '0;
    int          pend_acc;
    item_t       it;
    logic [33:0] mr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
            q.delete();
            model_acc  = '0;
            prev_stall = 1'b0;
        end else begin
            pend_acc = 0;
            foreach (q[i]) if (q[i].is_acc) pend_acc++;
            if (out_valid && q.size() > 0 && q[0].is_acc) pend_acc--;
            if (pend_acc > 0)
                chk("in_ready_acc_busy", {63'd0, in_ready}, 64'd0);
            else
                chk("in_ready_en", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});

            if (prev_stall) begin
                chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_hold_data", {30'd0, sum, cout, ovf}, {30'd0, prev_out});
            end

            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_output actual sum=%0h required no output", sum);
                end else begin
                    it = q[0];
                    if (it.lat_chk && !it.seen)
                        chk("latency", 64'(cycle - it.acc_cyc), 64'(NSLICE));
                    q[0].seen = 1'b1;
                    chk("result_vs_model", {30'd0, sum, cout, ovf},
                        {30'd0, it.sum, it.cout, it.ovf});
                    if (it.lit_chk && out_ready)
                        chk("result_literal", {30'd0, sum, cout, ovf},
                            {30'd0, it.lit_sum, it.lit_cout, it.lit_ovf});
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {sum, cout, ovf};

            if (in_valid && in_ready) begin
                mr         = model(mode, a, b, cin, acc_clr, model_acc);
                it.sum     = mr[31:0];
                it.cout    = mr[32];
                it.ovf     = mr[33];
                it.is_acc  = (mode == 2'b10);
                it.acc_cyc = cycle;
                it.lat_chk = lat_chk;
                it.seen    = 1'b0;
                it.lit_chk = lit_chk;
                it.lit_sum = lit_sum;
                it.lit_cout = lit_cout;
                it.lit_ovf = lit_ovf;
                q.push_back(it);
                if (mode == 2'b10) model_acc = mr[31:0];
                else if (acc_clr) model_acc = '0;
            end
        end
        if (done) begin
            chk("drained", 64'(q.size()), 64'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
    end

    task automatic send(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic clr, input logic lc,
                        input logic [31:0] ls, input logic lco, input logic lo,
                        input logic latc);
        int n;
        mode = m; a = x; b = y; cin = ci; acc_clr = clr;
        lit_chk = lc; lit_sum = ls; lit_cout = lco; lit_ovf = lo; lat_chk = latc;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 300) begin
                $display("FAIL accept_timeout waited %0d cycles, required in_ready", n);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lit_chk  = 1'b0;
        lat_chk  = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0) begin
            n++;
            if (n > 500) begin
                $display("FAIL drain_timeout %0d results outstanding, required 0", q.size());
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed beats with hand-computed results
        send(2'b00, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        drain();
        send(2'b11, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        send(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        send(2'b01, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send(2'b01, 32'd7, 32'd5, 1'b0, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
        drain();

        // Mixed add/sub stream under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++)
            send(2'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom % 2), 1'b0,
                 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 2));
            if (m == 2'b10) m = 2'b11;
            send(m, (i % 5 == 0) ? 32'h7FFF_FFF0 : $urandom,
                 (i % 7 == 0) ? 32'h0000_00F0 : $urandom, 1'($urandom % 2), 1'b0,
                 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        end
        drain();
        rand_rdy = 1'b0;

        // Accumulator sequence
        send(2'b10, 32'd10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
        send(2'b10, 32'd10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'd20, 1'b0, 1'b0, 1'b0);
        send(2'b10, 32'd10, 32'h0, 1'b1, 1'b0, 1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
        send(2'b10, 32'd3, 32'h0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        rand_rdy = 1'b1;
        for (int i = 0; i < 6; i++)
            send(2'b10, $urandom, $urandom, 1'b0, 1'($urandom % 3 == 0), 1'b0, 32'd0,
                 1'b0, 1'b0, 1'b0);
        drain();
        rand_rdy = 1'b0;

        // Clear on a non-accumulate beat: its own sum unaffected, acc zeroed afterwards
        send(2'b00, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        drain();
        send(2'b10, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        drain();

        // Reset mid-pipeline drops in-flight beats and clears acc
        send(2'b00, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        send(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(2'b00, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1);
        drain();
        send(2'b10, 32'h55, 32'd0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule
